// File: rtl/io_chan_pkg.sv
// Shared types and helpers for the core-to-channel I/O bridge.
package io_chan_pkg;

  localparam int DW_DEF = 28;

  // $clog2 that never returns 0, so single-entry selectors still get one bit
  function automatic int clog2f1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bit offset of channel ch inside a flat bus of w-bit words
  function automatic int chan_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/io_chan_bridge_fifo.sv
// One output channel: circular FIFO with a valid/ready head and occupancy count.
module chan_fifo
  import io_chan_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          full
);

  localparam int PW = clog2f1(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic [CW-1:0]            count;
  logic                     pop;

  // DEPTH is a power of two, so pointer wrap is plain overflow
  assign valid = rst & (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = valid & ready;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_chan_bridge.sv
// Core port interface to NCH_IN input / NCH_OUT output streaming channels.
module io_chan_bridge
  import io_chan_pkg::*;
#(
  parameter int NCH_IN  = 4,
  parameter int NCH_OUT = 4,
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = 4,
  parameter int AIW     = clog2f1(NCH_IN),
  parameter int AOW     = clog2f1(NCH_OUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AIW-1:0]        proc_addr_in,
  input  logic                  proc_req_in,
  output logic [DW-1:0]         proc_din,
  input  logic [AOW-1:0]        proc_addr_out,
  input  logic                  proc_out_en,
  input  logic [DW-1:0]         proc_dout,
  output logic                  proc_stall,
  input  logic [NCH_IN*DW-1:0]  in_data,
  input  logic [NCH_IN-1:0]     in_valid,
  output logic [NCH_IN-1:0]     in_ready,
  output logic [NCH_IN-1:0]     in_ack,
  output logic [NCH_OUT*DW-1:0] out_data,
  output logic [NCH_OUT-1:0]    out_valid,
  input  logic [NCH_OUT-1:0]    out_ready,
  output logic                  addr_err
);

  logic [NCH_IN-1:0][DW-1:0] hold;
  logic [NCH_IN-1:0]         full;
  logic [NCH_IN-1:0]         rd_sel;
  logic [NCH_OUT-1:0]        wr_sel;
  logic [NCH_OUT-1:0]        push;
  logic [NCH_OUT-1:0]        fifo_full;
  logic                      rd_stall, wr_stall, addr_bad;

  // Decode as one-hot so out-of-range addresses simply select nothing
  always_comb begin
    rd_sel   = '0;
    wr_sel   = '0;
    proc_din = '0;
    for (int i = 0; i < NCH_IN; i++) begin
      rd_sel[i] = (proc_addr_in == AIW'(i));
      if (rd_sel[i] && rst) proc_din = hold[i];
    end
    for (int j = 0; j < NCH_OUT; j++)
      wr_sel[j] = (proc_addr_out == AOW'(j));
  end

  always_comb begin
    in_ready   = rst ? ~full : '0;
    in_ack     = {NCH_IN{rst & proc_req_in}} & rd_sel & full;
    push       = {NCH_OUT{rst & proc_out_en}} & wr_sel & ~fifo_full;
    rd_stall   = rst & proc_req_in & (|rd_sel) & ~(|(rd_sel & full));
    // Write stall looks only at registered occupancy: no out_ready path
    wr_stall   = rst & proc_out_en & (|(wr_sel & fifo_full));
    proc_stall = rd_stall | wr_stall;
    addr_bad   = (proc_req_in & ~(|rd_sel)) | (proc_out_en & ~(|wr_sel));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold     <= '0;
      full     <= '0;
      addr_err <= 1'b0;
    end else begin
      for (int i = 0; i < NCH_IN; i++) begin
        if (in_valid[i] && !full[i]) begin
          hold[i] <= in_data[chan_lsb(i, DW) +: DW];
          full[i] <= 1'b1;
        end else if (in_ack[i]) begin
          full[i] <= 1'b0;
        end
      end
      if (addr_bad) addr_err <= 1'b1;
    end
  end

  for (genvar j = 0; j < NCH_OUT; j++) begin : g_out
    chan_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[j]),
      .din   (proc_dout),
      .ready (out_ready[j]),
      .dout  (out_data[j*DW +: DW]),
      .valid (out_valid[j]),
      .full  (fifo_full[j])
    );
  end

endmodule

// File: tb/tb_io_chan_bridge.sv
// Directed bench for io_chan_bridge: 4x4 instance plus a 3-input instance for address errors.
module tb_io_chan_bridge;

  localparam int DW = 28;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main 4x4 instance
  logic [1:0]      proc_addr_in, proc_addr_out;
  logic            proc_req_in, proc_out_en, proc_stall, addr_err;
  logic [DW-1:0]   proc_din, proc_dout;
  logic [4*DW-1:0] in_data, out_data;
  logic [3:0]      in_valid, in_ready, in_ack, out_valid, out_ready;

  io_chan_bridge #(.NCH_IN(4), .NCH_OUT(4), .DW(DW), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .proc_addr_in(proc_addr_in), .proc_req_in(proc_req_in), .proc_din(proc_din),
    .proc_addr_out(proc_addr_out), .proc_out_en(proc_out_en), .proc_dout(proc_dout),
    .proc_stall(proc_stall),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_ack(in_ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .addr_err(addr_err)
  );

  // 3-input instance: address 3 is out of range
  logic [1:0]      a3_addr_in, a3_addr_out;
  logic            a3_req, a3_en, a3_stall, a3_err;
  logic [DW-1:0]   a3_din, a3_dout;
  logic [3*DW-1:0] a3_in_data;
  logic [4*DW-1:0] a3_out_data;
  logic [2:0]      a3_in_valid, a3_in_ready, a3_in_ack;
  logic [3:0]      a3_out_valid, a3_out_ready;

  io_chan_bridge #(.NCH_IN(3), .NCH_OUT(4), .DW(DW), .DEPTH(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .proc_addr_in(a3_addr_in), .proc_req_in(a3_req), .proc_din(a3_din),
    .proc_addr_out(a3_addr_out), .proc_out_en(a3_en), .proc_dout(a3_dout),
    .proc_stall(a3_stall),
    .in_data(a3_in_data), .in_valid(a3_in_valid), .in_ready(a3_in_ready), .in_ack(a3_in_ack),
    .out_data(a3_out_data), .out_valid(a3_out_valid), .out_ready(a3_out_ready),
    .addr_err(a3_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drive just after the rising edge, sample on the falling edge
  task automatic step;
    @(posedge clk); #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    proc_addr_in = '0; proc_req_in = 1'b1; proc_addr_out = '0; proc_out_en = 1'b0;
    proc_dout = '0; in_data = '0; in_valid = 4'hF; out_ready = '0;
    a3_addr_in = '0; a3_req = 1'b0; a3_addr_out = '0; a3_en = 1'b0; a3_dout = '0;
    a3_in_data = '0; a3_in_valid = '0; a3_out_ready = '0;

    // reset held for 3 cycles with all inputs valid and a read pending
    for (int c = 0; c < 3; c++) begin
      step; smp;
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_stall", 32'(proc_stall), 32'h0);
      chk("rst_in_ack", 32'(in_ack), 32'h0);
    end
    step; rst = 1'b1; in_valid = '0; proc_req_in = 1'b0;
    smp;
    chk("rel_in_ready", 32'(in_ready), 32'hF);
    chk("rel_addr_err", 32'(addr_err), 32'h0);

    // input path on ch2
    step; in_data[2*DW +: DW] = 28'h0ABCDEF; in_valid = 4'b0100;
    smp;
    step; in_valid = '0;
    smp; chk("in_rdy2_k1", 32'(in_ready[2]), 32'h0);
    step; proc_req_in = 1'b1; proc_addr_in = 2'd2;
    smp;
    chk("in_rdy2_k2", 32'(in_ready[2]), 32'h0);
    chk("in_din2", 32'(proc_din), 32'h0ABCDEF);
    chk("in_ack2", 32'(in_ack), 32'h4);
    chk("in_stall2", 32'(proc_stall), 32'h0);
    step; proc_req_in = 1'b0;
    smp; chk("in_rdy2_k3", 32'(in_ready[2]), 32'h1);

    // empty read on ch1, then load while stalled
    step; proc_req_in = 1'b1; proc_addr_in = 2'd1;
    smp;
    chk("empty_stall", 32'(proc_stall), 32'h1);
    chk("empty_ack", 32'(in_ack), 32'h0);
    step; in_data[1*DW +: DW] = 28'h1234567; in_valid = 4'b0010;
    smp; chk("load_stall", 32'(proc_stall), 32'h1);
    step; in_valid = '0;
    smp;
    chk("post_load_stall", 32'(proc_stall), 32'h0);
    chk("post_load_ack", 32'(in_ack), 32'h2);
    chk("post_load_din", 32'(proc_din), 32'h1234567);
    step; proc_req_in = 1'b0;

    // output FIFO full on ch3
    out_ready = '0; proc_addr_out = 2'd3; proc_out_en = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      proc_dout = 28'(w);
      smp; chk("fill_stall", 32'(proc_stall), 32'h0);
      step;
    end
    proc_dout = 28'd5;
    smp;
    chk("full_stall", 32'(proc_stall), 32'h1);
    chk("full_valid", 32'(out_valid[3]), 32'h1);
    chk("full_head1", 32'(out_data[3*DW +: DW]), 32'h1);
    step; out_ready = 4'b1000;
    smp;
    chk("pop_stall_held", 32'(proc_stall), 32'h1);
    step; out_ready = '0;
    smp;
    chk("unblock_stall", 32'(proc_stall), 32'h0);
    chk("unblock_head2", 32'(out_data[3*DW +: DW]), 32'h2);
    step; proc_out_en = 1'b0; out_ready = 4'b1000;
    for (int d = 2; d <= 5; d++) begin
      smp;
      chk("drain_valid", 32'(out_valid[3]), 32'h1);
      chk("drain_data", 32'(out_data[3*DW +: DW]), 32'(d));
      step;
    end
    smp; chk("drain_empty", 32'(out_valid[3]), 32'h0);

    // wrap with continuous pop on ch0
    out_ready = 4'b0001; proc_addr_out = 2'd0; proc_out_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      proc_dout = 28'(32'h100 + i);
      smp;
      chk("wrap_stall", 32'(proc_stall), 32'h0);
      if (i > 0) begin
        chk("wrap_valid", 32'(out_valid[0]), 32'h1);
        chk("wrap_data", 32'(out_data[0 +: DW]), 32'h100 + 32'(i - 1));
      end
      step;
    end
    proc_out_en = 1'b0;
    smp; chk("wrap_last", 32'(out_data[0 +: DW]), 32'h109);
    step;
    smp; chk("wrap_empty", 32'(out_valid[0]), 32'h0);
    chk("main_no_err", 32'(addr_err), 32'h0);

    // out-of-range read on the 3-input instance
    step; a3_req = 1'b1; a3_addr_in = 2'd3;
    smp;
    chk("oor_din", 32'(a3_din), 32'h0);
    chk("oor_stall", 32'(a3_stall), 32'h0);
    chk("oor_err_pre", 32'(a3_err), 32'h0);
    step; a3_req = 1'b0;
    smp; chk("oor_err_set", 32'(a3_err), 32'h1);
    step; step;
    smp; chk("oor_err_sticky", 32'(a3_err), 32'h1);
    step; rst = 1'b0;
    smp;
    chk("oor_err_pre_rst", 32'(a3_err), 32'h1);
    chk("rst_din", 32'(proc_din), 32'h0);
    step;
    smp; chk("oor_err_cleared", 32'(a3_err), 32'h0);
    step; rst = 1'b1;
    smp; chk("final_in_ready", 32'(in_ready), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
